// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared constants for the instruction-memory loader: FSM state
//                encodings, default fill instruction and length encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // FSM state encoding
  localparam int         STATE_W  = 3;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  // Instruction presented to the core while it is held (a NOP-like value)
  localparam logic [7:0] FILL_DEFAULT = 8'h00;

  // A length byte of zero encodes the full memory depth (256 for 8-bit addresses)
  localparam bit LEN_ZERO_MEANS_MAX = 1'b1;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
//  Module      : imem_array
//  Description : DEPTH x DATA_W instruction storage, one synchronous write
//                port and one asynchronous (combinational) read port.
//                Contents are deliberately not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port: one word per clock when enabled; no reset so a program survives rst
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Zero-latency read for the core's fetch path
  assign o_rdata = r_mem[i_raddr];

endmodule : imem_array
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction-memory stage in front of the 8-bit core. Serves
//                fetches combinationally and accepts a length-prefixed,
//                checksummed program from a host over a valid/ready byte
//                stream, holding the core until a verified program (or an
//                explicit run request) is available.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(FILL_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,            // asynchronous, active-low
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] inst,
  input  logic              load_start,
  input  logic              run_req,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_len
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [STATE_W-1:0] r_state;
  logic               r_hold;
  logic               r_done;
  logic               r_err;
  logic [LEN_W-1:0]   r_prog_len;
  logic [LEN_W-1:0]   r_remaining;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [DATA_W-1:0]  r_csum;

  logic               w_xfer;
  logic               w_we;
  logic [LEN_W-1:0]   w_len_ext;
  logic [LEN_W-1:0]   w_len_dec;
  logic [DATA_W-1:0]  w_csum_next;
  logic [DATA_W-1:0]  w_rdata;

  // Ready only while a download is in progress
  assign load_ready = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);

  // load_start has priority: a byte presented on the same cycle is dropped
  assign w_xfer = load_valid && load_ready && !load_start;

  // Length byte decode: zero stands for the full depth
  assign w_len_ext = LEN_W'(load_data);
  assign w_len_dec = (LEN_ZERO_MEANS_MAX && (w_len_ext == '0)) ? LEN_W'(DEPTH) : w_len_ext;

  // Running byte sum; also used as the final check against the checksum byte
  assign w_csum_next = r_csum + load_data;

  assign w_we = (r_state == ST_DATA) && w_xfer;

  // Download FSM, counters, checksum and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_hold      <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_prog_len  <= '0;
      r_remaining <= '0;
      r_wr_ptr    <= '0;
      r_csum      <= '0;
    end else begin
      r_done <= 1'b0;
      if (load_start) begin
        r_state  <= ST_LEN;
        r_hold   <= 1'b1;
        r_err    <= 1'b0;
        r_wr_ptr <= '0;
        r_csum   <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_ERR: begin
            if (run_req) begin
              r_state <= ST_RUN;
              r_hold  <= 1'b0;
              r_err   <= 1'b0;
            end
          end
          ST_LEN: begin
            if (w_xfer) begin
              r_remaining <= w_len_dec;
              r_prog_len  <= w_len_dec;
              r_state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (w_xfer) begin
              r_csum      <= w_csum_next;
              r_wr_ptr    <= r_wr_ptr + 1'b1;
              r_remaining <= r_remaining - 1'b1;
              if (r_remaining == LEN_W'(1)) begin
                r_state <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (w_xfer) begin
              if (w_csum_next == '0) begin
                r_state <= ST_RUN;
                r_hold  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            r_state <= ST_RUN;
          end
          default: begin
            r_state <= ST_IDLE;
            r_hold  <= 1'b1;
          end
        endcase
      end
    end
  end

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (load_data),
    .i_raddr (read_address),
    .o_rdata (w_rdata)
  );

  // The core sees a harmless fill value whenever it is held
  assign inst      = r_hold ? FILL : w_rdata;
  assign cpu_hold  = r_hold;
  assign load_done = r_done;
  assign load_err  = r_err;
  assign prog_len  = r_prog_len;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader: directed downloads and
//                a table of expected fetch results per test phase.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] read_address;
  logic [7:0] inst;
  logic       load_start;
  logic       run_req;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [8:0] prog_len;

  int n_cmp = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    int         ph;
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t    tbl[$];
  logic [7:0] prog [0:263];
  int         prog_n;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W (8),
    .DATA_W (8),
    .FILL   (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .read_address (read_address),
    .inst         (inst),
    .load_start   (load_start),
    .run_req      (run_req),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .prog_len     (prog_len)
  );

  // Handshake and done-pulse monitors
  always @(posedge clk) begin
    if (rst && load_valid && load_ready) xfer_cnt++;
    if (load_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  function automatic rd_vec_t mk(input int ph, input logic [7:0] a, input logic [7:0] e);
    rd_vec_t v;
    v.ph = ph; v.addr = a; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reads(input int ph);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ph == ph) begin
        read_address = tbl[i].addr;
        #1;
        chk($sformatf("ph%0d inst@%02h", ph, tbl[i].addr), {8'h00, inst}, {8'h00, tbl[i].exp});
      end
    end
  endtask

  // Sends prog[0..prog_n-1]; gap idle cycles after each byte; returns on a negedge
  task automatic send_prog(input int gap, input bit with_start);
    if (with_start) begin
      @(negedge clk); load_start = 1'b1;
      @(negedge clk); load_start = 1'b0;
    end
    for (int i = 0; i < prog_n; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      @(negedge clk);
      load_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic set_good();
    prog[0] = 8'h03; prog[1] = 8'h45; prog[2] = 8'h12; prog[3] = 8'hC1; prog[4] = 8'hE8;
    prog_n = 5;
  endtask

  initial begin
    // Expected fetch results per phase
    tbl.push_back(mk(1, 8'h00, 8'h45)); tbl.push_back(mk(1, 8'h01, 8'h12));
    tbl.push_back(mk(1, 8'h02, 8'hC1));
    tbl.push_back(mk(2, 8'h01, 8'h12));
    tbl.push_back(mk(3, 8'h00, 8'h45)); tbl.push_back(mk(3, 8'h01, 8'h12));
    tbl.push_back(mk(3, 8'h02, 8'hC1));
    tbl.push_back(mk(4, 8'h00, 8'h00)); tbl.push_back(mk(4, 8'h7F, 8'h7F));
    tbl.push_back(mk(4, 8'h80, 8'h80)); tbl.push_back(mk(4, 8'hFF, 8'hFF));
    tbl.push_back(mk(5, 8'h00, 8'h7F)); tbl.push_back(mk(5, 8'h01, 8'hBB));
    tbl.push_back(mk(5, 8'h02, 8'h02)); tbl.push_back(mk(5, 8'hFF, 8'hFF));
    tbl.push_back(mk(6, 8'h00, 8'h5A)); tbl.push_back(mk(6, 8'h01, 8'hBB));

    rst = 1'b0; read_address = 8'h00; load_start = 1'b0; run_req = 1'b0;
    load_valid = 1'b0; load_data = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst hold", {15'd0, cpu_hold}, 16'd1);
    chk("rst ready", {15'd0, load_ready}, 16'd0);
    chk("rst done", {15'd0, load_done}, 16'd0);
    chk("rst err", {15'd0, load_err}, 16'd0);
    chk("rst prog_len", {7'd0, prog_len}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    read_address = 8'h55; #1;
    chk("post-rst inst", {8'h00, inst}, 16'h0000);
    chk("post-rst hold", {15'd0, cpu_hold}, 16'd1);

    // Good load, back to back
    set_good();
    send_prog(0, 1'b1);
    chk("good done", {15'd0, load_done}, 16'd1);
    chk("good hold", {15'd0, cpu_hold}, 16'd0);
    chk("good prog_len", {7'd0, prog_len}, 16'd3);
    @(negedge clk);
    chk("good done width", {15'd0, load_done}, 16'd0);
    check_reads(1);

    // Bad checksum, then run_req
    set_good(); prog[4] = 8'hE9;
    send_prog(0, 1'b1);
    chk("bad err", {15'd0, load_err}, 16'd1);
    chk("bad hold", {15'd0, cpu_hold}, 16'd1);
    chk("bad done", {15'd0, load_done}, 16'd0);
    read_address = 8'h01; #1;
    chk("bad inst fill", {8'h00, inst}, 16'h0000);
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    chk("run err clr", {15'd0, load_err}, 16'd0);
    chk("run hold", {15'd0, cpu_hold}, 16'd0);
    chk("run prog_len", {7'd0, prog_len}, 16'd3);
    check_reads(2);

    // Gapped stream: valid toggles every cycle
    set_good();
    @(negedge clk); xfer_cnt = 0; done_cnt = 0;
    send_prog(1, 1'b1);
    chk("gap xfers", xfer_cnt[15:0], 16'd5);
    chk("gap done pulses", done_cnt[15:0], 16'd1);
    chk("gap hold", {15'd0, cpu_hold}, 16'd0);
    chk("gap prog_len", {7'd0, prog_len}, 16'd3);
    check_reads(3);

    // Byte offered while running is ignored
    @(negedge clk); load_valid = 1'b1; load_data = 8'h99; #1;
    chk("run ready", {15'd0, load_ready}, 16'd0);
    @(negedge clk); load_valid = 1'b0;
    chk("run stays", {15'd0, cpu_hold}, 16'd0);
    check_reads(3);

    // Length 0 = 256 bytes, values 0..255, checksum 0x80
    prog[0] = 8'h00;
    for (int i = 0; i < 256; i++) prog[i+1] = 8'(i);
    prog[257] = 8'h80;
    prog_n = 258;
    send_prog(0, 1'b1);
    chk("256 done", {15'd0, load_done}, 16'd1);
    chk("256 prog_len", {7'd0, prog_len}, 16'd256);
    chk("256 err", {15'd0, load_err}, 16'd0);
    check_reads(4);

    // Restart mid-load: load_start with a byte on the same cycle
    prog[0] = 8'h03; prog[1] = 8'hAA; prog[2] = 8'hBB; prog_n = 3;
    send_prog(0, 1'b1);
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'hCC;
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b0;
    chk("restart ready", {15'd0, load_ready}, 16'd1);
    chk("restart hold", {15'd0, cpu_hold}, 16'd1);
    prog[0] = 8'h01; prog[1] = 8'h7F; prog[2] = 8'h81; prog_n = 3;
    send_prog(0, 1'b0);
    chk("restart done", {15'd0, load_done}, 16'd1);
    chk("restart prog_len", {7'd0, prog_len}, 16'd1);
    check_reads(5);

    // Reset in the middle of a download
    prog[0] = 8'h02; prog[1] = 8'h5A; prog_n = 2;
    send_prog(0, 1'b1);
    rst = 1'b0; #1;
    chk("midrst prog_len", {7'd0, prog_len}, 16'd0);
    chk("midrst hold", {15'd0, cpu_hold}, 16'd1);
    chk("midrst ready", {15'd0, load_ready}, 16'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    chk("midrst run hold", {15'd0, cpu_hold}, 16'd0);
    chk("midrst run prog_len", {7'd0, prog_len}, 16'd0);
    check_reads(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory stage directly upstream of the 8-bit processor core.
- Receives read_address from the core and returns the 8-bit instruction inst.
- Lets a host download a new program over a byte-wide valid/ready stream, length-prefixed and checksummed.
- Holds the core (cpu_hold) while loading or after a failed load; releases it only on a verified program or an explicit run request.

Parameters:
- ADDR_W, 8, instruction address width; memory depth is 2**ADDR_W words.
- DATA_W, 8, instruction width.
- FILL, 8'h00, instruction value driven on inst while cpu_hold=1.

Ports:
- clk  input  1  system clock (same as core clk).
- rst  input  1  asynchronous reset, active-low.
- read_address  input  ADDR_W  instruction fetch address from the core PC.
- inst  output  DATA_W  instruction at read_address (combinational read).
- load_start  input  1  single-cycle pulse; begins a new download.
- run_req  input  1  single-cycle pulse; runs the current memory contents without loading.
- load_valid  input  1  host byte valid.
- load_data  input  DATA_W  host byte.
- load_ready  output  1  block accepts a byte this cycle.
- cpu_hold  output  1  core must be held in reset/stalled while high.
- load_done  output  1  one-cycle pulse on successful checksum.
- load_err  output  1  level; checksum mismatch.
- prog_len  output  ADDR_W+1  byte count of the last accepted program, 1..256.

Behaviour:
- States: IDLE, LEN, DATA, CSUM, RUN, ERR.
- Reset (rst=0, async):
  - state=IDLE, cpu_hold=1, load_ready=0, load_done=0, load_err=0, prog_len=0.
  - Internal wr_ptr=0, remaining=0, csum=0.
  - Memory array is NOT reset; contents survive reset.
- Byte handshake: a byte transfers when load_valid && load_ready on a rising clk edge. load_ready=1 exactly in LEN, DATA and CSUM.
- load_start in any state: next state=LEN, wr_ptr=0, csum=0, load_err cleared. load_start wins over run_req and over a same-cycle byte transfer (that byte is dropped).
- run_req: acts only in IDLE and ERR. Next state=RUN, load_err cleared, prog_len unchanged. Ignored in every other state.
- LEN, on transfer:
  - remaining = load_data, with 0 meaning 256; prog_len = same value.
  - Next state=DATA.
- DATA, on transfer:
  - mem[wr_ptr] <= load_data; csum += load_data (mod 256); wr_ptr++ (wraps at 256); remaining--.
  - When remaining reaches 0, next state=CSUM.
- CSUM, on transfer:
  - If (csum + load_data) mod 256 == 0: next state=RUN, load_done=1 for exactly one cycle.
  - Otherwise: next state=ERR, load_err=1 (held until load_start or run_req).
- cpu_hold=0 only in RUN; cpu_hold=1 in all other states. cpu_hold is registered and changes on the same edge as the state.
- inst = FILL while cpu_hold=1; otherwise mem[read_address], combinational, zero-cycle latency.
- Memory words beyond the loaded length keep their previous contents.
- A write and a read of the same address never coincide, because the core is held during load.
- load_valid outside LEN, DATA and CSUM is ignored; no write, no state change.
- rst asserted mid-load: the load is aborted to IDLE. Bytes already written stay in memory; prog_len=0.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE..ERR);
  - FILL default;
  - the LEN_ZERO_MEANS_MAX encoding constant (0 -> 256).
- Sub-module imem_array: DEPTH x DATA_W storage with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata).
- The FSM, counters and checksum stay in imem_loader.

Test Plan:
- Reset: rst low then high -> cpu_hold=1, inst=8'h00 for any read_address, load_ready=0, prog_len=0.
- Good load: start, bytes 03,45,12,C1, csum E8 ->
  - load_done pulses 1 cycle after the E8 transfer; cpu_hold=0; prog_len=3.
  - read_address 0/1/2 -> inst 45/12/C1.
- Bad checksum: same program with csum E9 -> load_err=1, cpu_hold=1, inst=FILL. Then run_req -> RUN, load_err=0, inst at addr 1 = 12.
- Backpressure and gaps: load_valid toggled 1/0 every cycle during the good load -> identical result; exactly 5 transfers counted.
- Length 0 meaning 256: 256 bytes with values i, then the correct csum (0x80) -> prog_len=256, wr_ptr wraps, inst at FF = FF.
- Restart mid-load: load_start after 2 data bytes, with load_valid high on the same cycle -> that byte is dropped, state=LEN. A full new load of 01,7F,81 -> load_done, inst at 0 = 7F.
